// File: rtl/coef_readout_if.sv
// rtl/coef_readout_if.sv - 16-bit valid/ready word stream from the coefficient readout to the host FIFO.
interface coef_readout_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/coef_readout.sv
// rtl/coef_readout.sv - reads the 64x64 coefficient image out of ram2 as odd/even pairs
// and serialises it, even word first, onto a back-pressured 16-bit stream.
module coef_readout #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 12,
  parameter int WORDS      = 4096,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              end_flag,
  input  logic [DATA_W-1:0] ram_q_odd,
  input  logic [DATA_W-1:0] ram_q_even,
  output logic [ADDR_W-1:0] address_a_input,
  output logic [ADDR_W-1:0] address_b_input,
  coef_readout_if.master    dout_if,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam logic [ADDR_W-2:0] LAST_PAIR = (ADDR_W-1)'(WORDS/2 - 1);

  state_e              state_q, state_d;
  logic                end_flag_dly_q, end_flag_dly_d;
  logic [ADDR_W-2:0]   pair_idx_q, pair_idx_d, out_idx_q, out_idx_d, issue_idx;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [2*DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d, inflight;
  logic                phase_q, phase_d, busy_q, busy_d, done_q, done_d;
  logic                start, abort, credit, issue, push, pop, xfer, valid, last, fifo_full;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe_q[i]);
  end

  // Reads already in the RAM pipe count against FIFO space, so a capture never finds it full.
  assign credit    = (count_q + inflight) < CW'(FIFO_DEPTH);
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign start     = (state_q == S_IDLE) && end_flag && !end_flag_dly_q;
  assign abort     = ((state_q == S_READ) || (state_q == S_DRAIN)) && !end_flag;
  assign issue     = start || ((state_q == S_READ) && end_flag && credit);
  assign issue_idx = start ? '0 : pair_idx_q;
  assign push      = pipe_q[RD_LAT-1];
  assign valid     = (count_q != '0);
  assign xfer      = valid && dout_if.dout_ready;
  assign pop       = xfer && phase_q;
  assign last      = valid && phase_q && (out_idx_q == LAST_PAIR);

  assign dout_if.dout       = !valid ? '0 :
                              (phase_q ? mem_q[rd_ptr_q][2*DATA_W-1:DATA_W] : mem_q[rd_ptr_q][DATA_W-1:0]);
  assign dout_if.dout_valid = valid;
  assign dout_if.dout_last  = last;
  assign address_a_input    = addr_a_q;
  assign address_b_input    = addr_b_q;
  assign busy               = busy_q;
  assign done               = done_q;

  always_comb begin
    state_d        = state_q;
    end_flag_dly_d = end_flag;
    pair_idx_d     = pair_idx_q;
    out_idx_d      = out_idx_q;
    addr_a_d       = addr_a_q;
    addr_b_d       = addr_b_q;
    pipe_d         = (pipe_q << 1) | RD_LAT'(issue);
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    phase_d        = phase_q;
    count_d        = count_q + CW'(push) - CW'(pop);

    if (issue) begin
      addr_b_d   = {issue_idx, 1'b0};
      addr_a_d   = {issue_idx, 1'b1};
      pair_idx_d = issue_idx + (ADDR_W-1)'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = {ram_q_odd, ram_q_even};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (xfer) phase_d = ~phase_q;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      out_idx_d = out_idx_q + (ADDR_W-1)'(1);
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = (issue_idx == LAST_PAIR) ? S_DRAIN : S_READ;
        out_idx_d = '0;
      end
      S_READ:  if (issue && (pair_idx_q == LAST_PAIR)) state_d = S_DRAIN;
      S_DRAIN: if (xfer && last) state_d = S_DONE;
      S_DONE:  if (!end_flag) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      pipe_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      phase_d   = 1'b0;
      out_idx_d = '0;
    end

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // end_flag history resets high so a level still held across reset is not taken as a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      end_flag_dly_q <= 1'b1;
      pair_idx_q     <= '0;
      out_idx_q      <= '0;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      pipe_q         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      phase_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      end_flag_dly_q <= end_flag_dly_d;
      pair_idx_q     <= pair_idx_d;
      out_idx_q      <= out_idx_d;
      addr_a_q       <= addr_a_d;
      addr_b_q       <= addr_b_d;
      pipe_q         <= pipe_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      phase_q        <= phase_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule
